// File: rtl/capture_reg_arbiter.sv
// Round-robin arbiter that lends one shared capture register to a requester for
// HOLD_CYC cycles, then pulses ack to the owner and returns to idle.
module capture_reg_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 8,
  parameter int HOLD_CYC = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          grant,
  output logic [N_REQ-1:0]          ack,
  output logic [DATA_W-1:0]         q,
  output logic                      q_valid,
  output logic                      busy
);

  localparam int PTR_W = $clog2(N_REQ);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;

  logic                win_found;
  logic [PTR_W-1:0]    win_idx;
  logic [PTR_W-1:0]    idx_w;

  // State register; the reset pointer of N_REQ-1 gives requester 0 first priority.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= PTR_W'(N_REQ - 1);
      grant_q <= '0;
      ack_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // Winner: first set req bit scanning ptr+1, ptr+2, ... with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx_w     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx_w = PTR_W'((int'(ptr_q) + k) % N_REQ);
      if (!win_found && req[idx_w]) begin
        win_found = 1'b1;
        win_idx   = idx_w;
      end
    end
  end

  // Next-state logic.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    ack_d   = '0;
    data_d  = data_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        // A pending ack blocks arbitration for one cycle so the owner can drop req.
        if (ack_q == '0 && win_found) begin
          state_d          = HOLD;
          cnt_d            = 8'(HOLD_CYC - 1);
          ptr_d            = win_idx;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          data_d           = req_data[int'(win_idx)*DATA_W +: DATA_W];
          valid_d          = 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = IDLE;
          ack_d   = grant_q;
          grant_d = '0;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    busy    = (state_q == HOLD);
    grant   = grant_q;
    ack     = ack_q;
    q       = data_q;
    q_valid = valid_q;
  end

endmodule

// File: tb/tb_capture_reg_arbiter.sv
// Scoreboard bench for capture_reg_arbiter: two instances (HOLD_CYC=2 and 1) share
// stimulus; a transaction-level model predicts grants and acks from latency rules.
module tb_capture_reg_arbiter;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int NDUT = 2;

  typedef struct {
    int          id;
    logic [W-1:0] data;
    int          cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;

  logic [N-1:0]   grant_w [NDUT];
  logic [N-1:0]   ack_w   [NDUT];
  logic [W-1:0]   q_w     [NDUT];
  logic           qv_w    [NDUT];
  logic           busy_w  [NDUT];

  exp_t           gq [NDUT][$];
  exp_t           aq [NDUT][$];
  int             ptr_m    [NDUT];
  int             next_arb [NDUT];
  logic [W-1:0]   last_q   [NDUT];
  logic [N-1:0]   prev_g   [NDUT];

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  bit  rst_prev = 1'b1;
  bit  done = 1'b0;
  bit  final_done = 1'b0;

  always #5 clk = ~clk;

  capture_reg_arbiter #(.N_REQ(N), .DATA_W(W), .HOLD_CYC(2)) u_dut_h2 (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .grant    (grant_w[0]),
    .ack      (ack_w[0]),
    .q        (q_w[0]),
    .q_valid  (qv_w[0]),
    .busy     (busy_w[0])
  );

  capture_reg_arbiter #(.N_REQ(N), .DATA_W(W), .HOLD_CYC(1)) u_dut_h1 (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .grant    (grant_w[1]),
    .ack      (ack_w[1]),
    .q        (q_w[1]),
    .q_valid  (qv_w[1]),
    .busy     (busy_w[1])
  );

  function automatic int hold_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  task automatic check(input bit ok, input string name, input int d,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got 0x%0h expected 0x%0h", name, d, cyc, act, exp);
    end
  endtask

  // Transaction model: a grant issued for inputs seen in cycle t occupies cycles
  // t+1..t+H, acks in t+H+1, and the next arbitration may use inputs of t+H+2.
  function automatic void model_reset(input int d);
    gq[d].delete();
    aq[d].delete();
    ptr_m[d]    = N - 1;
    next_arb[d] = cyc;
  endfunction

  function automatic void model_arb(input int d, input logic [N-1:0] r, input logic [N*W-1:0] dat);
    exp_t e;
    if (cyc >= next_arb[d] && r != '0) begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (ptr_m[d] + k) % N;
        if (r[idx]) begin
          e.id   = idx;
          e.data = dat[idx*W +: W];
          e.cyc  = cyc + 1;
          gq[d].push_back(e);
          e.cyc  = cyc + hold_of(d) + 1;
          aq[d].push_back(e);
          ptr_m[d]    = idx;
          next_arb[d] = cyc + hold_of(d) + 2;
          break;
        end
      end
    end
  endfunction

  // Inputs are applied 1 time unit after a rising edge and held for the whole cycle.
  task automatic step(input logic [N-1:0] r, input logic [N*W-1:0] dat, input bit do_rst);
    rst      = do_rst;
    req      = r;
    req_data = dat;
    for (int d = 0; d < NDUT; d++) begin
      if (do_rst) begin
        model_reset(d);
      end else begin
        if (rst_prev) model_reset(d);
        model_arb(d, r, dat);
      end
    end
    rst_prev = do_rst;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Monitor: samples on the falling edge and pops the scoreboard as outputs appear.
  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      exp_t e;
      if (rst) begin
        check(grant_w[d] == '0 && ack_w[d] == '0 && q_w[d] == '0 && !qv_w[d] && !busy_w[d],
              "reset_state", d,
              32'({grant_w[d], ack_w[d], q_w[d], qv_w[d], busy_w[d]}), 32'd0);
        last_q[d] = '0;
        prev_g[d] = '0;
      end else begin
        check($onehot0(grant_w[d]) && $onehot0(ack_w[d]) && !(grant_w[d] != '0 && ack_w[d] != '0),
              "onehot", d, 32'({grant_w[d], ack_w[d]}), 32'd0);
        check(qv_w[d] == (grant_w[d] != '0) && busy_w[d] == (grant_w[d] != '0),
              "status", d, 32'({qv_w[d], busy_w[d]}), 32'({2{grant_w[d] != '0}}));
        if (gq[d].size() > 0) begin
          check(gq[d][0].cyc >= cyc, "grant_overdue", d, 32'(cyc), 32'(gq[d][0].cyc));
          if (gq[d][0].cyc < cyc) void'(gq[d].pop_front());
        end
        if (aq[d].size() > 0) begin
          check(aq[d][0].cyc >= cyc, "ack_overdue", d, 32'(cyc), 32'(aq[d][0].cyc));
          if (aq[d][0].cyc < cyc) void'(aq[d].pop_front());
        end
        if (grant_w[d] != '0 && prev_g[d] == '0) begin
          check(gq[d].size() > 0, "grant_unexpected", d, 32'(grant_w[d]), 32'd0);
          if (gq[d].size() > 0) begin
            e = gq[d].pop_front();
            check(grant_w[d] == (N'(1) << e.id) && q_w[d] == e.data && e.cyc == cyc,
                  "grant_start", d, {16'(cyc), 4'd0, grant_w[d], q_w[d]},
                  {16'(e.cyc), 4'd0, N'(1) << e.id, e.data});
            last_q[d] = e.data;
          end
        end else if (grant_w[d] != '0) begin
          check(grant_w[d] == prev_g[d] && q_w[d] == last_q[d], "grant_hold", d,
                32'({grant_w[d], q_w[d]}), 32'({prev_g[d], last_q[d]}));
        end else begin
          check(q_w[d] == last_q[d], "q_retain", d, 32'(q_w[d]), 32'(last_q[d]));
        end
        if (ack_w[d] != '0) begin
          check(aq[d].size() > 0, "ack_unexpected", d, 32'(ack_w[d]), 32'd0);
          if (aq[d].size() > 0) begin
            e = aq[d].pop_front();
            check(ack_w[d] == (N'(1) << e.id) && e.cyc == cyc, "ack", d,
                  {16'(cyc), 12'd0, ack_w[d]}, {16'(e.cyc), 12'd0, N'(1) << e.id});
          end
        end
        prev_g[d] = grant_w[d];
      end
      if (done && !final_done) begin
        check(gq[d].size() == 0 && aq[d].size() == 0, "drain", d,
              32'(gq[d].size() + aq[d].size()), 32'd0);
      end
    end
    if (done) final_done = 1'b1;
  end

  initial begin
    logic [N*W-1:0] dat;
    logic [N-1:0]   r;
    int             rst_left;

    repeat (3) step('0, '0, 1'b1);

    // Single request, data 0xA5.
    dat = '0;
    dat[7:0] = 8'hA5;
    step(4'b0001, dat, 1'b0);
    repeat (6) step('0, dat, 1'b0);

    // All requesters held: rotation 0,1,2,3,0.
    repeat (22) step(4'b1111, $urandom, 1'b0);
    repeat (5) step('0, '0, 1'b0);

    // Only requester 0 held after a fresh reset.
    repeat (2) step('0, '0, 1'b1);
    repeat (13) step(4'b0001, $urandom, 1'b0);
    repeat (4) step('0, '0, 1'b0);

    // Requester 1 drops req and changes data mid-hold.
    repeat (2) step('0, '0, 1'b1);
    dat = '0;
    dat[15:8] = 8'h3C;
    step(4'b0010, dat, 1'b0);
    dat[15:8] = 8'hFF;
    repeat (5) step('0, dat, 1'b0);

    // Reset in the second hold cycle of a transfer owned by requester 2.
    repeat (2) step('0, '0, 1'b1);
    dat = '0;
    dat[23:16] = 8'h5A;
    step(4'b0100, dat, 1'b0);
    step(4'b0100, dat, 1'b0);
    step(4'b0100, dat, 1'b1);
    dat[7:0] = 8'h11;
    repeat (6) step(4'b0101, dat, 1'b0);
    repeat (4) step('0, '0, 1'b0);

    // Randomized traffic with occasional resets.
    rst_left = 0;
    for (int i = 0; i < 3000; i++) begin
      r = N'($urandom);
      if ($urandom_range(99) < 15) r = '0;
      if (rst_left == 0 && $urandom_range(199) == 0) rst_left = 1 + $urandom_range(1);
      step(r, $urandom, rst_left > 0);
      if (rst_left > 0) rst_left--;
    end
    repeat (10) step('0, '0, 1'b0);

    done = 1'b1;
    for (int i = 0; i < 10 && !final_done; i++) @(posedge clk);
    if (!final_done) begin
      $display("FAIL drain_timeout: monitor did not complete, got 0 expected 1");
      $fatal(1, "drain timeout");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/capture_reg_arbiter.md
CAPTURE_REG_ARBITER -- requirements
Module: capture_reg_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4: number of requesters; legal range 2..16.
REQ-002 The block SHALL have parameter DATA_W, default 8: width of the shared capture register.
REQ-003 The block SHALL have parameter HOLD_CYC, default 2: cycles a captured value is held valid; legal range 1..255.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port req, input, N_REQ bits: per-requester request level.
REQ-007 The block SHALL have port req_data, input, N_REQ*DATA_W bits: requester i's data at bits [i*DATA_W +: DATA_W].
REQ-008 The block SHALL have port grant, output, N_REQ bits: registered, one-hot or zero, owner of the shared register.
REQ-009 The block SHALL have port ack, output, N_REQ bits: registered, one-cycle completion pulse to the owner.
REQ-010 The block SHALL have port q, output, DATA_W bits: shared capture register contents.
REQ-011 The block SHALL have port q_valid, output, 1 bit: q holds a granted requester's data.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-013 The FSM SHALL have exactly two states, IDLE and HOLD, plus an 8-bit down-counter cnt and a round-robin pointer ptr of width clog2(N_REQ).
REQ-014 In IDLE with ack all-zero and req nonzero, the winner SHALL be the first set req bit searching ptr+1, ptr+2, ... modulo N_REQ.
REQ-015 At the same edge, the block SHALL set grant to the winner's one-hot value, load q with the winner's req_data and set q_valid=1, cnt=HOLD_CYC-1, ptr=winner, state=HOLD.
REQ-016 In IDLE with ack nonzero, arbitration SHALL be suppressed for that cycle, giving requesters one cycle to drop req.
REQ-017 In HOLD with cnt>0, cnt SHALL decrement; grant, q and q_valid SHALL be unchanged.
REQ-018 In HOLD with cnt==0, the next edge SHALL pulse ack for the owner, clear grant and q_valid, and return to IDLE; q SHALL retain its last value.
REQ-019 Latency SHALL be: req seen in IDLE in cycle t -> grant/q_valid in cycles t+1..t+HOLD_CYC -> ack in cycle t+HOLD_CYC+1 -> earliest next grant in cycle t+HOLD_CYC+3.
REQ-020 req_data SHALL be sampled only at the load edge; later changes to req or req_data SHALL NOT affect q, hold length or ack.
REQ-021 A requester dropping req during HOLD SHALL NOT abort the transfer; ack SHALL still be issued.
REQ-022 At most one bit of grant and of ack SHALL ever be set, and ack SHALL never coincide with grant.
REQ-023 busy SHALL be decoded combinationally from the registered state only.

Reset
REQ-024 While rst=1, asynchronously: state=IDLE, grant=0, ack=0, q=0, q_valid=0, cnt=0, ptr=N_REQ-1, so requester 0 has first priority.
REQ-025 Reset asserted mid-HOLD SHALL abandon the transfer immediately with no ack; the first arbitration after release SHALL use the reset pointer.
REQ-026 Deassertion of rst SHALL take effect at the first clk rising edge after release.

Verification (N_REQ=4, DATA_W=8, HOLD_CYC=2 unless stated)
REQ-027 Stimulus: req=0001, data0=0xA5 in cycle 0. Response: grant=0001, q=0xA5, q_valid=1 in cycles 1-2; ack=0001 in cycle 3; q stays 0xA5 with q_valid=0 after.
REQ-028 Stimulus: req=1111 held. Response: grant order 0001, 0010, 0100, 1000, 0001, with grants 4 cycles apart.
REQ-029 Stimulus: only req0 held high. Response: grant=0001 in cycles 1, 5, 9; ack=0001 in cycles 3, 7, 11.
REQ-030 Stimulus: grant to req1 with data1=0x3C; drop req1 and change data1 to 0xFF in cycle 1. Response: q=0x3C through cycle 2; ack=0010 in cycle 3.
REQ-031 Stimulus: rst pulsed in cycle 2 of a hold owned by req2; after release req=0101. Response: immediate grant=0, q=0, no ack; next grant=0001.
REQ-032 Stimulus: HOLD_CYC=1, req=0010. Response: q_valid for exactly one cycle (cycle 1); ack in cycle 2; next grant no earlier than cycle 4.
